cmp_flag_unit: RTL
==================

Name: cmp_flag_unit

Overview:
Parametrised compare/test unit for the processor datapath; the next generation of the single-cycle zero/carry comparator. Computes A−B (CMP) or A&B (TST) and commits Z/C/N/V into a held flag register, with a valid handshake and an optional input pipeline stage. Evaluates a branch condition code against the held flags for the control unit.

Parameters:
WIDTH, 18, operand width in bits (≥2)
PIPE, 1, 0 = flags commit 1 cycle after in_valid; 1 = extra input register stage, flags commit 2 cycles after in_valid

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request, one op per asserted cycle
op  input  1  0 = CMP (A−B), 1 = TST (A&B)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
flags_clr  input  1  synchronous clear of flag register
cond  input  3  condition code to evaluate
zf  output  1  zero flag (registered)
cf  output  1  borrow flag, A<B unsigned (registered)
nf  output  1  negative flag (registered)
vf  output  1  signed overflow flag (registered)
flags_valid  output  1  one-cycle pulse on the cycle the flags update
busy  output  1  op in flight in pipe stage (always 0 when PIPE=0)
cond_true  output  1  combinational evaluation of cond against held flags

Behaviour:
- Reset (Reset_n=0, async): zf=cf=nf=vf=0, flags_valid=0, busy=0, pipe stage valid cleared; in-flight op discarded, never commits.
- CMP: diff = {0,a} − {0,b}, WIDTH+1 bits. zf = (diff[WIDTH-1:0]==0); cf = diff[WIDTH]; nf = diff[WIDTH-1]; vf = (a[MSB]^b[MSB]) & (a[MSB]^diff[WIDTH-1]).
- TST: r = a&b; zf = (r==0); nf = r[WIDTH-1]; cf=0; vf=0.
- PIPE=0: in_valid at edge k -> flags and flags_valid=1 visible after edge k.
- PIPE=1: edge k captures op/a/b into stage (busy=1); edge k+1 computes and commits flags, flags_valid=1. Full throughput: back-to-back in_valid commits on consecutive cycles in order; busy stays 1 while stage holds a valid op.
- Flags hold their value between commits; flags_valid=0 on cycles without a commit.
- flags_clr alone: all four flags -> 0 at next edge, flags_valid stays 0.
- flags_clr on the same edge as a commit: commit wins (newer result); clr ignored. flags_clr never kills an op in the pipe stage.
- in_valid=0: operands ignored, no state change (pipe stage valid clears).
- cond_true: 0 EQ=Z, 1 NE=!Z, 2 LTU=C, 3 GEU=!C, 4 LT=N^V, 5 GE=!(N^V), 6 GTU=!C&!Z, 7 AL=1. Evaluated on held register outputs, not on in-flight results.
- All arithmetic modulo 2^WIDTH; no X propagation from unused operands.

Decomposition:
- Shared package cmp_pkg: op encodings (OP_CMP=0, OP_TST=1), condition codes COND_EQ..COND_AL as 3-bit constants, flag bit index constants (Z=3, C=2, N=1, V=0) for packed-flag users.
- One sub-module: cmp_flag_calc (purely combinational, WIDTH-parametrised, op/a/b -> z,c,n,v), instantiated after the optional pipe register. cond evaluation stays in the top.

Test Plan:
- Reset: hold Reset_n=0 mid-stream with in_valid=1 -> zf=cf=nf=vf=0, flags_valid=0, busy=0; release -> no stale commit.
- CMP a=5, b=5, cond=EQ, PIPE=1 -> flags_valid pulses 2 cycles after in_valid; zf=1, cf=0, nf=0, vf=0; cond_true=1; cond=NE -> 0.
- CMP a=3, b=7 -> diff=0x3FFFC; cf=1, nf=1, zf=0, vf=0; LTU=1, LT=1, GTU=0.
- CMP a=0x20000, b=0x00001 (WIDTH=18) -> diff=0x1FFFF; nf=0, vf=1, cf=0; LT=1, LTU=0, GEU=1.
- TST a=0x000F0, b=0x0000F -> zf=1, cf=0, vf=0, nf=0; then TST a=0x20000, b=0x3FFFF -> zf=0, nf=1.
- Back-to-back CMP (9,2) then (2,9), flags_clr asserted on first commit edge -> flags_valid high 2 consecutive cycles, first commit unaffected by clr, final cf=1; then flags_clr alone -> all flags 0, flags_valid=0. Repeat with PIPE=0 for 1-cycle latency.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared encodings for the compare/test unit: op codes, branch condition codes and
// bit positions of the packed Z/C/N/V flag word.
package cmp_pkg;

  localparam logic OP_CMP = 1'b0;
  localparam logic OP_TST = 1'b1;

  localparam logic [2:0] COND_EQ  = 3'd0;
  localparam logic [2:0] COND_NE  = 3'd1;
  localparam logic [2:0] COND_LTU = 3'd2;
  localparam logic [2:0] COND_GEU = 3'd3;
  localparam logic [2:0] COND_LT  = 3'd4;
  localparam logic [2:0] COND_GE  = 3'd5;
  localparam logic [2:0] COND_GTU = 3'd6;
  localparam logic [2:0] COND_AL  = 3'd7;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cmp_flag_calc.sv
// Combinational flag generator: CMP computes A-B with borrow, TST computes A&B.
module cmp_flag_calc
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v
);

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r;

  // Zero-extended subtract so the top bit is the unsigned borrow.
  assign diff = {1'b0, a} - {1'b0, b};
  assign r    = a & b;

  always_comb begin
    z = 1'b0;
    c = 1'b0;
    n = 1'b0;
    v = 1'b0;
    case (op)
      OP_CMP: begin
        z = (diff[WIDTH-1:0] == '0);
        c = diff[WIDTH];
        n = diff[WIDTH-1];
        v = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]);
      end
      OP_TST: begin
        z = (r == '0);
        n = r[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cmp_flag_unit.sv
// Compare/test unit: optional operand stage, held Z/C/N/V flag register with
// commit pulse, and branch condition evaluation against the held flags.
module cmp_flag_unit
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned PIPE  = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             in_valid,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flags_clr,
  input  logic [2:0]       cond,
  output logic             zf,
  output logic             cf,
  output logic             nf,
  output logic             vf,
  output logic             flags_valid,
  output logic             busy,
  output logic             cond_true
);

  logic             calc_valid;
  logic             calc_op;
  logic [WIDTH-1:0] calc_a;
  logic [WIDTH-1:0] calc_b;
  logic             calc_z, calc_c, calc_n, calc_v;

  if (PIPE != 0) begin : g_pipe
    logic             stg_valid_q;
    logic             stg_op_q;
    logic [WIDTH-1:0] stg_a_q;
    logic [WIDTH-1:0] stg_b_q;

    // Operands load only with a valid op so idle-cycle junk never reaches the datapath.
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
        stg_valid_q <= 1'b0;
        stg_op_q    <= 1'b0;
        stg_a_q     <= '0;
        stg_b_q     <= '0;
      end else begin
        stg_valid_q <= in_valid;
        if (in_valid) begin
          stg_op_q <= op;
          stg_a_q  <= a;
          stg_b_q  <= b;
        end
      end
    end

    assign calc_valid = stg_valid_q;
    assign calc_op    = stg_op_q;
    assign calc_a     = stg_a_q;
    assign calc_b     = stg_b_q;
    assign busy       = stg_valid_q;
  end else begin : g_nopipe
    assign calc_valid = in_valid;
    assign calc_op    = in_valid & op;
    assign calc_a     = in_valid ? a : '0;
    assign calc_b     = in_valid ? b : '0;
    assign busy       = 1'b0;
  end

  cmp_flag_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op(calc_op),
    .a (calc_a),
    .b (calc_b),
    .z (calc_z),
    .c (calc_c),
    .n (calc_n),
    .v (calc_v)
  );

  logic [3:0] flags_q;
  logic       flags_valid_q;

  // A commit beats a simultaneous clear: the newer result is kept.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
    end else begin
      flags_valid_q <= calc_valid;
      if (calc_valid) begin
        flags_q[FLAG_Z] <= calc_z;
        flags_q[FLAG_C] <= calc_c;
        flags_q[FLAG_N] <= calc_n;
        flags_q[FLAG_V] <= calc_v;
      end else if (flags_clr) begin
        flags_q <= '0;
      end
    end
  end

  assign zf          = flags_q[FLAG_Z];
  assign cf          = flags_q[FLAG_C];
  assign nf          = flags_q[FLAG_N];
  assign vf          = flags_q[FLAG_V];
  assign flags_valid = flags_valid_q;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      COND_EQ:  cond_true = zf;
      COND_NE:  cond_true = !zf;
      COND_LTU: cond_true = cf;
      COND_GEU: cond_true = !cf;
      COND_LT:  cond_true = nf ^ vf;
      COND_GE:  cond_true = !(nf ^ vf);
      COND_GTU: cond_true = !cf && !zf;
      COND_AL:  cond_true = 1'b1;
    endcase
  end

endmodule
